// File: rtl/wrr_pkt_arbiter_if.sv
// Handshake bundle between the packet read units, the WRR arbiter and egress.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface wrr_pkt_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int WEIGHT_W   = 4
);
    logic [NUM_CH*DATA_WIDTH-1:0] iData;
    logic [NUM_CH-1:0]            iVld;
    logic [NUM_CH-1:0]            iLast;
    logic [NUM_CH-1:0]            oRdy;
    logic [NUM_CH*WEIGHT_W-1:0]   iWeight;
    logic [DATA_WIDTH-1:0]        oData;
    logic                         oVld;
    logic                         oLast;
    logic                         iRdy;
    logic [NUM_CH-1:0]            oGrant;
    logic                         oBusy;

    modport slave (
        input  iData, iVld, iLast, iWeight, iRdy,
        output oRdy, oData, oVld, oLast, oGrant, oBusy
    );

    modport master (
        output iData, iVld, iLast, iWeight, iRdy,
        input  oRdy, oData, oVld, oLast, oGrant, oBusy
    );
endinterface

// File: rtl/wrr_pkt_arbiter.sv
// Packet-granular weighted round-robin merge of NUM_CH read-unit streams.
// Channels switch only on packet boundaries; egress is one register stage.
module wrr_pkt_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int WEIGHT_W   = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    wrr_pkt_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                  state;
    state_t                  stateNxt;

    logic [WEIGHT_W-1:0]     credit    [NUM_CH];
    logic [WEIGHT_W-1:0]     creditEff [NUM_CH];
    logic [WEIGHT_W-1:0]     wgt       [NUM_CH];
    logic [NUM_CH-1:0]       elig;
    logic [NUM_CH-1:0]       grant;
    logic [PTR_W-1:0]        rPtr;
    logic [PTR_W-1:0]        gIdx;
    logic [PTR_W-1:0]        gNext;
    logic [PTR_W-1:0]        winIdx;
    logic [PTR_W-1:0]        idx;
    logic [PTR_W:0]          sum;
    logic                    win;
    logic                    anyCredit;
    logic                    anyWeight;
    logic                    reload;

    logic [DATA_WIDTH-1:0]   gData;
    logic                    gVld;
    logic                    gLast;
    logic                    outRdy;
    logic                    accept;
    logic                    eop;

    logic [DATA_WIDTH-1:0]   dataQ;
    logic                    vldQ;
    logic                    lastQ;

    // Reload check, effective credits and rotating first-eligible search
    always_comb begin
        anyCredit = 1'b0;
        anyWeight = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            wgt[k] = bus.iWeight[k*WEIGHT_W +: WEIGHT_W];
            if (bus.iVld[k] && credit[k] != '0) anyCredit = 1'b1;
            if (bus.iVld[k] && wgt[k] != '0)    anyWeight = 1'b1;
        end
        reload = (state == IDLE) && !anyCredit && anyWeight;
        for (int k = 0; k < NUM_CH; k++) begin
            creditEff[k] = reload ? wgt[k] : credit[k];
            elig[k]      = bus.iVld[k] && (creditEff[k] != '0);
        end
        win    = 1'b0;
        winIdx = '0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, rPtr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_CH)) sum = sum - (PTR_W+1)'(NUM_CH);
            idx = sum[PTR_W-1:0];
            if (!win && elig[idx]) begin
                win    = 1'b1;
                winIdx = idx;
            end
        end
    end

    // Granted-channel mux and egress handshake qualifiers
    always_comb begin
        gData = '0;
        gVld  = 1'b0;
        gLast = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant[k]) begin
                gData = bus.iData[k*DATA_WIDTH +: DATA_WIDTH];
                gVld  = bus.iVld[k];
                gLast = bus.iLast[k];
            end
        end
        outRdy = !vldQ || bus.iRdy;
        accept = (state == XFER) && gVld && outRdy;
        eop    = accept && gLast;
        gNext  = (gIdx == PTR_W'(NUM_CH-1)) ? '0 : gIdx + PTR_W'(1);
    end

    // Next-state: grant leaves IDLE, accepted last word returns to it
    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE: if (win) stateNxt = XFER;
            XFER: if (eop) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= stateNxt;
    end

    // Grant, credit and round-robin pointer bookkeeping
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            grant <= '0;
            gIdx  <= '0;
            rPtr  <= '0;
            for (int k = 0; k < NUM_CH; k++) credit[k] <= '0;
        end else if (state == IDLE) begin
            if (reload) begin
                for (int k = 0; k < NUM_CH; k++) credit[k] <= creditEff[k];
            end
            if (win) begin
                grant <= NUM_CH'(1) << winIdx;
                gIdx  <= winIdx;
            end
        end else if (eop) begin
            grant <= '0;
            if (credit[gIdx] != '0) begin
                credit[gIdx] <= credit[gIdx] - WEIGHT_W'(1);
            end
            rPtr <= (credit[gIdx] <= WEIGHT_W'(1)) ? gNext : gIdx;
        end
    end

    // Egress register: load on accept, clear valid once drained
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            dataQ <= '0;
            vldQ  <= 1'b0;
            lastQ <= 1'b0;
        end else if (accept) begin
            dataQ <= gData;
            lastQ <= gLast;
            vldQ  <= 1'b1;
        end else if (bus.iRdy) begin
            vldQ  <= 1'b0;
        end
    end

    assign bus.oRdy   = grant & {NUM_CH{outRdy}};
    assign bus.oData  = dataQ;
    assign bus.oVld   = vldQ;
    assign bus.oLast  = lastQ;
    assign bus.oGrant = grant;
    assign bus.oBusy  = (state == XFER);
endmodule
